// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: MEM-stage FSM states, WB control bit positions and datapath widths.
package mips_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_W      = 5;

    localparam int REG_WRITE  = 1;
    localparam int MEM_TO_REG = 0;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Memory-wait timer: reloads to TIMEOUT_CYCLES on clear and counts down while enabled;
// expired flags the terminal count, i.e. TIMEOUT_CYCLES wait cycles have elapsed.
module mem_wait_timer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] remaining;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            remaining <= LOAD;
        end else if (clear) begin
            remaining <= LOAD;
        end else if (enable && !expired) begin
            remaining <= remaining - 1'b1;
        end
    end

    assign expired = (remaining == '0);

endmodule

// File: rtl/stage_mem.sv
// MIPS MEM stage: branch resolution, req/ack data-memory access with timeout, MEM/WB registers.
// Build option STAGE_MEM_MISALIGN_TRAP_EN: refuse misaligned accesses and pulse misalign_o.
//
// state | meaning
// IDLE  | pass-through, or issue a memory access when mem_read|mem_write
// WAIT  | access outstanding; hold pipeline until dmem_ack or timer expiry
module stage_mem
    import mips_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [DATA_W-1:0] data_b,
    input  logic [REG_W-1:0]  regaddr,
    input  logic [1:0]        wbi,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              zero,
    input  logic              is_jump,
    input  logic              branch_eq,
    input  logic              branch_inc,
    input  logic [DATA_W-1:0] jump_address,
    output logic              pc_src_o,
    output logic [DATA_W-1:0] pc_target_o,
    output logic              stall_o,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic [1:0]        wbi_o,
    output logic [REG_W-1:0]  regaddr_o,
    output logic [DATA_W-1:0] alu_out_o,
    output logic [DATA_W-1:0] mem_data_o,
    output logic              bus_err_o
`ifdef STAGE_MEM_MISALIGN_TRAP_EN
    ,
    output logic              misalign_o
`endif
);

    mem_state_t state, state_nxt;

    logic              access;
    logic              misaligned;
    logic              trap;
    logic              issue;
    logic              complete;
    logic              timeout;
    logic              timer_expired;
    logic [1:0]        hold_wbi;
    logic [REG_W-1:0]  hold_regaddr;
    logic [DATA_W-1:0] hold_alu_out;

    assign access = mem_read | mem_write;

`ifdef STAGE_MEM_MISALIGN_TRAP_EN
    assign misaligned = (alu_out[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign trap  = (state == IDLE) & access & misaligned;
    assign issue = (state == IDLE) & access & !misaligned;

    // Combinational outputs are forced low while reset is held.
    assign pc_src_o    = !reset & (is_jump | (branch_eq & zero) | (branch_inc & !zero));
    assign pc_target_o = reset ? '0 : jump_address;

    mem_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (issue),
        .enable  ((state == WAIT) & !dmem_ack),
        .expired (timer_expired)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (issue) state_nxt = WAIT;
            WAIT:    if (dmem_ack || timer_expired) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        stall_o  = 1'b0;
        complete = 1'b0;
        timeout  = 1'b0;
        case (state)
            IDLE: begin
                stall_o = issue & !reset;
            end
            WAIT: begin
                complete = dmem_ack;
                timeout  = !dmem_ack & timer_expired;
                stall_o  = !dmem_ack & !timer_expired & !reset;
            end
            default: begin
                stall_o = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_wdata   <= '0;
            wbi_o        <= '0;
            regaddr_o    <= '0;
            alu_out_o    <= '0;
            mem_data_o   <= '0;
            bus_err_o    <= 1'b0;
            hold_wbi     <= '0;
            hold_regaddr <= '0;
            hold_alu_out <= '0;
        end else begin
            bus_err_o <= timeout;
            if (issue) begin
                dmem_req     <= 1'b1;
                dmem_we      <= mem_write;
                dmem_addr    <= {alu_out[DATA_W-1:2], 2'b00};
                dmem_wdata   <= data_b;
                hold_wbi     <= wbi;
                hold_regaddr <= regaddr;
                hold_alu_out <= alu_out;
                wbi_o        <= '0;
            end else if (state == IDLE) begin
                wbi_o     <= trap ? 2'b00 : wbi;
                regaddr_o <= regaddr;
                alu_out_o <= alu_out;
            end else if (complete) begin
                dmem_req  <= 1'b0;
                wbi_o     <= hold_wbi;
                regaddr_o <= hold_regaddr;
                alu_out_o <= hold_alu_out;
                if (!dmem_we) begin
                    mem_data_o <= dmem_rdata;
                end
            end else if (timeout) begin
                dmem_req <= 1'b0;
                wbi_o    <= '0;
            end else begin
                wbi_o <= '0;
            end
        end
    end

`ifdef STAGE_MEM_MISALIGN_TRAP_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            misalign_o <= 1'b0;
        end else begin
            misalign_o <= trap;
        end
    end
`endif

endmodule
